// File: rtl/matrix_pkg.sv
// Shared defaults, FSM state type and width helper for the matrix slice streamer.
package matrix_pkg;

    localparam int DEF_ROWS   = 64;
    localparam int DEF_COLS   = 10;
    localparam int DEF_DATA_W = 16;
    localparam int DEF_GROUPS = 4;

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

    // Ceiling log2 clamped to at least one bit so single-entry indices stay legal.
    function automatic int clog2_min1(input int value);
        int w;
        w = 0;
        while ((1 << w) < value) w++;
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/matrix_slice_stream.sv
// Captures a full matrix and streams it out as GROUPS row-slices, forward or reverse,
// with valid/ready handshaking, abort flush and a completion pulse.
module matrix_slice_stream
    import matrix_pkg::*;
#(
    parameter int ROWS   = DEF_ROWS,
    parameter int COLS   = DEF_COLS,
    parameter int DATA_W = DEF_DATA_W,
    parameter int GROUPS = DEF_GROUPS
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic                                          in_valid,
    output logic                                          in_ready,
    input  logic signed [ROWS*COLS*DATA_W-1:0]            in_matrix,
    input  logic                                          in_rev,
    input  logic                                          abort,
    output logic                                          out_valid,
    input  logic                                          out_ready,
    output logic signed [ROWS*COLS*DATA_W/GROUPS-1:0]     out_slice,
    output logic [clog2_min1(GROUPS)-1:0]                 out_idx,
    output logic                                          out_last,
    output logic                                          finish
);

    localparam int MAT_W   = ROWS * COLS * DATA_W;
    localparam int SLICE_W = MAT_W / GROUPS;
    localparam int IDX_W   = clog2_min1(GROUPS);
    localparam int SEL_W   = clog2_min1(MAT_W);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(GROUPS - 1);

    state_t                   state_q, state_d;
    logic [IDX_W-1:0]         cnt_q, cnt_d;
    logic signed [MAT_W-1:0]  mat_q;
    logic                     rev_q;
    logic                     finish_q, finish_d;
    logic                     load;
    logic                     is_last;
    logic [SEL_W-1:0]         sel_base;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            mat_q    <= '0;
            rev_q    <= 1'b0;
            finish_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            finish_q <= finish_d;
            if (load) begin
                mat_q <= in_matrix;
                rev_q <= in_rev;
            end
        end
    end

    // The terminal slice depends on direction: highest index going forward, zero in reverse.
    assign is_last = rev_q ? (cnt_q == '0) : (cnt_q == LAST_IDX);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        finish_d = 1'b0;
        load     = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid && !abort) begin
                    load    = 1'b1;
                    state_d = STREAM;
                    cnt_d   = in_rev ? LAST_IDX : '0;
                end
            end
            STREAM: begin
                // Abort wins over a completing handshake and suppresses the finish pulse.
                if (abort) begin
                    state_d = IDLE;
                end else if (out_ready) begin
                    if (is_last) begin
                        state_d  = IDLE;
                        finish_d = 1'b1;
                    end else begin
                        cnt_d = rev_q ? (cnt_q - 1'b1) : (cnt_q + 1'b1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == STREAM);
    assign out_last  = out_valid & is_last;
    assign out_idx   = out_valid ? cnt_q : '0;
    assign finish    = finish_q;

    // Slice 0 sits in the MSBs, so the selection walks down from the top of the register.
    always_comb begin
        sel_base  = SEL_W'(MAT_W - 1) - SEL_W'(cnt_q) * SEL_W'(SLICE_W);
        out_slice = '0;
        if (out_valid) begin
            out_slice = mat_q[sel_base -: SLICE_W];
        end
    end

endmodule

// File: tb/tb_matrix_slice_stream.sv
// Scoreboard bench for matrix_slice_stream: default build plus a single-slice 8-row build.
module tb_matrix_slice_stream;

    localparam int R       = 64;
    localparam int C       = 10;
    localparam int W       = 16;
    localparam int G       = 4;
    localparam int RPS     = R / G;
    localparam int MAT_W   = R * C * W;
    localparam int SLICE_W = MAT_W / G;
    localparam int R1      = 8;
    localparam int MAT1_W  = R1 * C * W;

    typedef struct {
        logic [SLICE_W-1:0] slice;
        int                 idx;
        bit                 last;
    } beat_t;

    logic clk = 1'b0;
    logic rst;

    logic                       in_valid, in_ready, in_rev, abort;
    logic signed [MAT_W-1:0]    in_matrix;
    logic                       out_valid, out_ready, out_last, finish;
    logic signed [SLICE_W-1:0]  out_slice;
    logic [1:0]                 out_idx;

    logic                       in_valid1, in_ready1, in_rev1, abort1;
    logic signed [MAT1_W-1:0]   in_matrix1;
    logic                       out_valid1, out_ready1, out_last1, finish1;
    logic signed [MAT1_W-1:0]   out_slice1;
    logic [0:0]                 out_idx1;

    int checks = 0;
    int passes = 0;
    beat_t sb[$];
    logic [MAT1_W-1:0] sb1[$];
    beat_t b;
    logic [MAT1_W-1:0] b1;
    bit exp_fin = 1'b0;

    always #5 clk = ~clk;

    matrix_slice_stream dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_matrix(in_matrix), .in_rev(in_rev), .abort(abort),
        .out_valid(out_valid), .out_ready(out_ready), .out_slice(out_slice),
        .out_idx(out_idx), .out_last(out_last), .finish(finish)
    );

    matrix_slice_stream #(.ROWS(R1), .COLS(C), .DATA_W(W), .GROUPS(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
        .in_matrix(in_matrix1), .in_rev(in_rev1), .abort(abort1),
        .out_valid(out_valid1), .out_ready(out_ready1), .out_slice(out_slice1),
        .out_idx(out_idx1), .out_last(out_last1), .finish(finish1)
    );

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("[TB] FAIL %s: actual %0d required %0d", name, act, exp);
    endtask

    task automatic cmpSlice(input string name, input logic [SLICE_W-1:0] act, input logic [SLICE_W-1:0] exp);
        int e;
        checks++;
        if (act === exp) begin
            passes++;
        end else begin
            e = 0;
            while (e < SLICE_W / W - 1 && act[SLICE_W-1-e*W -: W] === exp[SLICE_W-1-e*W -: W]) e++;
            $display("[TB] FAIL %s: element %0d actual %0d required %0d", name, e,
                     act[SLICE_W-1-e*W -: W], exp[SLICE_W-1-e*W -: W]);
        end
    endtask

    function automatic logic [MAT_W-1:0] make_matrix(input int base);
        logic [MAT_W-1:0] m;
        m = '0;
        for (int r = 0; r < R; r++)
            for (int c = 0; c < C; c++)
                m[MAT_W-1-(r*C+c)*W -: W] = W'(base + r*C + c);
        return m;
    endfunction

    function automatic logic [MAT1_W-1:0] make_matrix1(input int base);
        logic [MAT1_W-1:0] m;
        m = '0;
        for (int r = 0; r < R1; r++)
            for (int c = 0; c < C; c++)
                m[MAT1_W-1-(r*C+c)*W -: W] = W'(base + r*C + c);
        return m;
    endfunction

    function automatic logic [SLICE_W-1:0] exp_slice(input int base, input int k);
        logic [SLICE_W-1:0] s;
        s = '0;
        for (int rr = 0; rr < RPS; rr++)
            for (int c = 0; c < C; c++)
                s[SLICE_W-1-(rr*C+c)*W -: W] = W'(base + (k*RPS + rr)*C + c);
        return s;
    endfunction

    // Monitor for the default build: pops the scoreboard on every accepted beat.
    always @(negedge clk) begin
        if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
                checkOutput("unexpected beat idx", out_idx, 64'hFFFF);
            end else begin
                b = sb.pop_front();
                checkOutput("beat idx", out_idx, b.idx);
                checkOutput("beat last", out_last, b.last);
                cmpSlice("beat slice", out_slice, b.slice);
            end
        end
        if (exp_fin || finish) checkOutput("finish pulse", finish, exp_fin);
        exp_fin = out_valid && out_ready && out_last && !abort && !rst;
    end

    always @(negedge clk) begin
        if (out_valid1 && out_ready1) begin
            if (sb1.size() == 0) begin
                checkOutput("g1 unexpected beat", out_valid1, 1'b0);
            end else begin
                b1 = sb1.pop_front();
                checkOutput("g1 beat last", out_last1, 1'b1);
                cmpSlice("g1 beat slice", SLICE_W'(out_slice1), SLICE_W'(b1));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic waitIdle();
        int n;
        n = 0;
        while (!in_ready && n < 50) begin
            step();
            n++;
        end
        if (!in_ready) checkOutput("wait in_ready timeout", in_ready, 1'b1);
    endtask

    task automatic applyStimulus(input int base, input bit rev, input int npush);
        int k;
        waitIdle();
        for (int j = 0; j < npush; j++) begin
            k = rev ? G - 1 - j : j;
            sb.push_back('{slice: exp_slice(base, k), idx: k, last: (k == (rev ? 0 : G - 1))});
        end
        in_matrix = make_matrix(base);
        in_rev    = rev;
        in_valid  = 1'b1;
        step();
        in_valid  = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_rev = 1'b0; abort = 1'b0; out_ready = 1'b1;
        in_matrix = '0;
        in_valid1 = 1'b0; in_rev1 = 1'b0; abort1 = 1'b0; out_ready1 = 1'b0;
        in_matrix1 = '0;
        repeat (3) step();
        checkOutput("reset out_valid", out_valid, 0);
        checkOutput("reset out_slice", out_slice == '0, 1);
        checkOutput("reset out_idx", out_idx, 0);
        checkOutput("reset out_last", out_last, 0);
        checkOutput("reset finish", finish, 0);
        rst = 1'b0;
        step();
        checkOutput("in_ready after reset", in_ready, 1);

        // Forward, element (r,c) = r*COLS+c.
        applyStimulus(0, 1'b0, 4);
        checkOutput("fwd first idx", out_idx, 0);
        step();
        checkOutput("fwd second idx", out_idx, 1);
        checkOutput("slice1 first element", out_slice[SLICE_W-1 -: W], 160);
        repeat (3) step();
        checkOutput("fwd finish", finish, 1);
        checkOutput("fwd valid after last", out_valid, 0);
        checkOutput("fwd in_ready after last", in_ready, 1);
        step();
        checkOutput("fwd finish one cycle", finish, 0);

        // Reverse: slice 3 first, rows 48..63.
        applyStimulus(1000, 1'b1, 4);
        checkOutput("rev first idx", out_idx, 3);
        checkOutput("rev first top element", out_slice[SLICE_W-1 -: W], 1480);
        checkOutput("rev first bottom element", out_slice[W-1:0], 1639);
        repeat (3) step();
        checkOutput("rev final idx", out_idx, 0);
        checkOutput("rev final last", out_last, 1);
        step();
        checkOutput("rev finish", finish, 1);

        // Back-pressure at idx 2 for five cycles.
        applyStimulus(7, 1'b0, 4);
        step();
        step();
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            checkOutput("stall idx", out_idx, 2);
            checkOutput("stall valid", out_valid, 1);
            cmpSlice("stall slice", out_slice, exp_slice(7, 2));
        end
        out_ready = 1'b1;
        step();
        checkOutput("after stall idx", out_idx, 3);
        step();
        checkOutput("stall finish", finish, 1);

        // Abort on the last-slice handshake.
        applyStimulus(50, 1'b0, 4);
        repeat (3) step();
        checkOutput("abort at last", out_last, 1);
        abort = 1'b1;
        step();
        abort = 1'b0;
        checkOutput("abort in_ready", in_ready, 1);
        checkOutput("abort valid", out_valid, 0);
        checkOutput("abort finish", finish, 0);
        step();
        checkOutput("abort finish later", finish, 0);

        // Abort in IDLE blocks a same-cycle capture.
        in_matrix = make_matrix(5);
        in_valid  = 1'b1;
        abort     = 1'b1;
        step();
        in_valid  = 1'b0;
        abort     = 1'b0;
        checkOutput("idle abort no capture", out_valid, 0);
        checkOutput("idle abort in_ready", in_ready, 1);

        // Reset pulsed while idx 1 is presented.
        applyStimulus(200, 1'b0, 1);
        step();
        checkOutput("pre-reset idx", out_idx, 1);
        rst = 1'b1;
        #1;
        checkOutput("mid reset valid", out_valid, 0);
        checkOutput("mid reset idx", out_idx, 0);
        checkOutput("mid reset slice", out_slice == '0, 1);
        checkOutput("mid reset last", out_last, 0);
        checkOutput("mid reset finish", finish, 0);
        step();
        rst = 1'b0;
        step();
        checkOutput("post reset finish", finish, 0);
        applyStimulus(300, 1'b0, 4);
        checkOutput("restart idx", out_idx, 0);
        checkOutput("restart top element", out_slice[SLICE_W-1 -: W], 300);
        waitIdle();
        step();

        // Single-slice build: second in_valid during STREAM is ignored.
        in_matrix1 = make_matrix1(11);
        in_valid1  = 1'b1;
        step();
        in_matrix1 = make_matrix1(99);
        for (int i = 0; i < 2; i++) begin
            checkOutput("g1 valid", out_valid1, 1);
            checkOutput("g1 in_ready", in_ready1, 0);
            checkOutput("g1 last", out_last1, 1);
            checkOutput("g1 idx", out_idx1, 0);
            checkOutput("g1 top element", out_slice1[MAT1_W-1 -: W], 11);
            cmpSlice("g1 slice held", SLICE_W'(out_slice1), SLICE_W'(make_matrix1(11)));
            step();
        end
        sb1.push_back(make_matrix1(11));
        in_valid1  = 1'b0;
        out_ready1 = 1'b1;
        step();
        checkOutput("g1 finish", finish1, 1);
        checkOutput("g1 valid after", out_valid1, 0);
        step();
        checkOutput("g1 finish one cycle", finish1, 0);

        repeat (3) step();
        checkOutput("scoreboard drained", sb.size(), 0);
        checkOutput("g1 scoreboard drained", sb1.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
